// File: rtl/dct_tr_ctl.sv
// Transpose-memory controller between the two 1D stages of a 2D DCT: rows in, columns out.
// Optional ping-pong banking is enabled by defining DCT_TR_PINGPONG_EN; default is a single bank.
module dct_tr_ctl #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_inverse,
  input  logic [1:0]        i_size,
  output logic              o_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_wr_bank,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_bank,
  output logic              o_valid,
  output logic              o_inverse,
  output logic [1:0]        o_size,
  output logic              o_last,
  output logic [0:0]        o_dbg_state
);

  // Handshake: a row is taken on a rising edge where i_valid & o_ready are both high;
  // i_valid while o_ready is low is dropped, never queued.

`ifdef DCT_TR_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_READ = 1'b1;

  logic [0:0]        state, state_nxt;
  logic              wr_bank, rd_bank;
  logic [1:0]        full, full_nxt;
  logic [1:0]        set_mask, clr_mask;
  logic [1:0]        inv_b;
  logic [1:0]        size_b [2];
  logic [ADDR_W-1:0] wr_cnt, rd_cnt;
  logic [1:0]        wr_size, rd_size;
  logic              accept, wr_done, rd_done;
  logic              rd_bank_nxt;

  // Index of the final row/column for a given size code: N-1 with N = 4 << size.
  function automatic logic [ADDR_W-1:0] last_idx(input logic [1:0] s);
    logic [7:0] n;
    n = (8'd4 << s) - 8'd1;
    return n[ADDR_W-1:0];
  endfunction

  assign o_ready     = ~full[wr_bank];
  assign accept      = i_valid & o_ready;
  // The first row of a block decides its length, so use the live size on row 0.
  assign wr_size     = (wr_cnt == '0) ? i_size : size_b[wr_bank];
  assign wr_done     = accept & (wr_cnt == last_idx(wr_size));
  assign rd_size     = size_b[rd_bank];
  assign rd_done     = (state == S_READ) & (rd_cnt == last_idx(rd_size));
  assign rd_bank_nxt = PP ? ~rd_bank : 1'b0;

  assign o_wr_en     = accept;
  assign o_wr_addr   = wr_cnt;
  assign o_wr_bank   = wr_bank;
  assign o_rd_en     = (state == S_READ);
  assign o_rd_addr   = rd_cnt;
  assign o_rd_bank   = rd_bank;
  assign o_dbg_state = state;

  always_comb begin
    set_mask = 2'b00;
    clr_mask = 2'b00;
    if (wr_done) set_mask[wr_bank] = 1'b1;
    if (rd_done) clr_mask[rd_bank] = 1'b1;
    full_nxt = (full & ~clr_mask) | set_mask;
  end

  // A block finishing on the same edge as the previous read keeps READ without a bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (full_nxt[rd_bank]) state_nxt = S_READ;
      S_READ: if (rd_done) state_nxt = full_nxt[rd_bank_nxt] ? S_READ : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      full      <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      inv_b     <= 2'b00;
      size_b[0] <= 2'd0;
      size_b[1] <= 2'd0;
    end else begin
      state <= state_nxt;
      full  <= full_nxt;
      if (accept && (wr_cnt == '0)) begin
        size_b[wr_bank] <= i_size;
        inv_b[wr_bank]  <= i_inverse;
      end
      if (wr_done) begin
        wr_cnt  <= '0;
        wr_bank <= PP ? ~wr_bank : 1'b0;
      end else if (accept) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (rd_done) begin
        rd_cnt  <= '0;
        rd_bank <= rd_bank_nxt;
      end else if (state == S_READ) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  // Memory returns data one cycle after the read, so the column sideband is delayed to match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid   <= 1'b0;
      o_inverse <= 1'b0;
      o_size    <= 2'd0;
      o_last    <= 1'b0;
    end else begin
      o_valid   <= o_rd_en;
      o_inverse <= o_rd_en & inv_b[rd_bank];
      o_size    <= o_rd_en ? rd_size : 2'd0;
      o_last    <= rd_done;
    end
  end

endmodule

// File: tb/tb_dct_tr_ctl.sv
// Directed bench for dct_tr_ctl; expectations are hand-derived cycle by cycle.
// Sections specific to the ping-pong build are selected with DCT_TR_PINGPONG_EN.
module tb_dct_tr_ctl;

  localparam int ADDR_W = 5;
`ifdef DCT_TR_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid, i_inverse;
  logic [1:0]        i_size;
  logic              o_ready, o_wr_en, o_wr_bank, o_rd_en, o_rd_bank;
  logic [ADDR_W-1:0] o_wr_addr, o_rd_addr;
  logic              o_valid, o_inverse, o_last;
  logic [1:0]        o_size;
  logic [0:0]        o_dbg_state;

  int tests = 0;
  int fails = 0;

  dct_tr_ctl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_inverse(i_inverse), .i_size(i_size),
    .o_ready(o_ready), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_bank(o_wr_bank),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_rd_bank(o_rd_bank),
    .o_valid(o_valid), .o_inverse(o_inverse), .o_size(o_size), .o_last(o_last),
    .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic v, input logic inv, input logic [1:0] sz);
    @(negedge clk);
    i_valid   = v;
    i_inverse = inv;
    i_size    = sz;
    #1;
  endtask

  task automatic chk_idle_outputs(input string ph);
    chk({ph, ".valid"},   {31'b0, o_valid}, 32'd0);
    chk({ph, ".last"},    {31'b0, o_last}, 32'd0);
    chk({ph, ".inverse"}, {31'b0, o_inverse}, 32'd0);
    chk({ph, ".size"},    {30'b0, o_size}, 32'd0);
    chk({ph, ".rd_en"},   {31'b0, o_rd_en}, 32'd0);
    chk({ph, ".ready"},   {31'b0, o_ready}, 32'd1);
  endtask

  task automatic do_reset(input string ph);
    @(negedge clk);
    i_valid = 1'b0; i_inverse = 1'b0; i_size = 2'd0;
    rst = 1'b1;
    #1;
    chk_idle_outputs(ph);
    chk({ph, ".wr_en"}, {31'b0, o_wr_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic exp_cycle(input string ph, input int c,
                           input bit we, input int wa, input bit wb, input bit rdy,
                           input bit re, input int ra, input bit rb,
                           input bit vld, input bit lst, input bit inv, input int sz);
    string t;
    t = $sformatf("%s[%0d]", ph, c);
    chk({t, ".wr_en"}, {31'b0, o_wr_en}, {31'b0, we});
    if (we) begin
      chk({t, ".wr_addr"}, {27'b0, o_wr_addr}, wa);
      chk({t, ".wr_bank"}, {31'b0, o_wr_bank}, {31'b0, wb});
    end
    chk({t, ".ready"}, {31'b0, o_ready}, {31'b0, rdy});
    chk({t, ".rd_en"}, {31'b0, o_rd_en}, {31'b0, re});
    if (re) begin
      chk({t, ".rd_addr"}, {27'b0, o_rd_addr}, ra);
      chk({t, ".rd_bank"}, {31'b0, o_rd_bank}, {31'b0, rb});
    end
    chk({t, ".valid"},   {31'b0, o_valid}, {31'b0, vld});
    chk({t, ".last"},    {31'b0, o_last}, {31'b0, lst});
    chk({t, ".inverse"}, {31'b0, o_inverse}, {31'b0, inv});
    chk({t, ".size"},    {30'b0, o_size}, sz);
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_inverse = 1'b0; i_size = 2'd0;
    do_reset("reset");

    // One 4x4 forward block, rows back-to-back; reads in cycles 5-8, columns in 6-9.
    for (int c = 1; c <= 10; c++) begin
      tick(c <= 4, 1'b0, 2'd0);
      exp_cycle("fwd4", c, c <= 4, c - 1, 1'b0, PP || !(c >= 5 && c <= 8),
                c >= 5 && c <= 8, c - 5, 1'b0, c >= 6 && c <= 9, c == 9, 1'b0, 0);
    end

`ifndef DCT_TR_PINGPONG_EN
    // 8x8 inverse block with i_size toggled to 3 from row 3 and i_valid held high:
    // rows during the read are dropped, then a 4x4 forward block starts at address 0.
    for (int c = 1; c <= 26; c++) begin
      tick(c <= 20, c <= 16, (c <= 3) ? 2'd1 : ((c <= 16) ? 2'd3 : 2'd0));
      exp_cycle("single8", c,
                (c <= 8) || (c >= 17 && c <= 20),
                (c <= 8) ? c - 1 : c - 17, 1'b0,
                !((c >= 9 && c <= 16) || (c >= 21 && c <= 24)),
                (c >= 9 && c <= 16) || (c >= 21 && c <= 24),
                (c <= 16) ? c - 9 : c - 21, 1'b0,
                (c >= 10 && c <= 17) || (c >= 22 && c <= 25),
                (c == 17) || (c == 25),
                c >= 10 && c <= 17,
                (c >= 10 && c <= 17) ? 1 : 0);
    end
`else
    // 8x8 inverse into bank 0, 4x4 forward into bank 1 during its read, then both banks
    // full with i_valid held high: no write until bank 0 drains, then bank 0 takes the row.
    do_reset("pp_reset");
    for (int c = 1; c <= 22; c++) begin
      tick(c <= 17, c <= 8, (c <= 8) ? 2'd1 : 2'd0);
      exp_cycle("pp", c,
                (c <= 12) || (c == 17),
                (c <= 8) ? c - 1 : ((c <= 12) ? c - 9 : 0),
                c >= 9 && c <= 12,
                !(c >= 13 && c <= 16),
                c >= 9 && c <= 20,
                (c <= 16) ? c - 9 : c - 17,
                c >= 17,
                c >= 10 && c <= 21,
                (c == 17) || (c == 21),
                c >= 10 && c <= 17,
                (c >= 10 && c <= 17) ? 1 : 0);
    end
    do_reset("pp_reset2");
`endif

    // Reset asserted mid-read: sideband clears at once, nothing emerges afterwards.
    for (int c = 1; c <= 7; c++) begin
      tick(c <= 4, 1'b1, 2'd0);
      exp_cycle("rdrst", c, c <= 4, c - 1, 1'b0, PP || c <= 4,
                c >= 5, c - 5, 1'b0, c >= 6, 1'b0, c >= 6, 0);
    end
    rst = 1'b1;
    #1;
    chk_idle_outputs("rdrst.async");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick(1'b0, 1'b0, 2'd0);
      chk($sformatf("rdrst.after[%0d].valid", c), {31'b0, o_valid}, 32'd0);
      chk($sformatf("rdrst.after[%0d].rd_en", c), {31'b0, o_rd_en}, 32'd0);
    end

    // Reset on row 10 of a 16x16 block: the partial rows are discarded and the
    // next block restarts at address 0 instead of completing the old one.
    for (int c = 1; c <= 10; c++) begin
      tick(1'b1, 1'b0, 2'd2);
      chk($sformatf("blkrst[%0d].wr_addr", c), {27'b0, o_wr_addr}, c - 1);
    end
    tick(1'b0, 1'b0, 2'd2);
    rst = 1'b1;
    #1;
    chk_idle_outputs("blkrst.async");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick(1'b1, 1'b0, 2'd2);
      chk($sformatf("blkrst.new[%0d].wr_en", c), {31'b0, o_wr_en}, 32'd1);
      chk($sformatf("blkrst.new[%0d].wr_addr", c), {27'b0, o_wr_addr}, c - 1);
    end
    for (int c = 1; c <= 4; c++) begin
      tick(1'b0, 1'b0, 2'd0);
      chk($sformatf("blkrst.idle[%0d].rd_en", c), {31'b0, o_rd_en}, 32'd0);
      chk($sformatf("blkrst.idle[%0d].valid", c), {31'b0, o_valid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
